// File: rtl/rx78_pixel_fetch.sv
// rx78_pixel_fetch
//   Video-side reader of the six RX-78 VRAM planes (fg1-3, bg1-3). Derives the
//   shared VRAM read address from the beam position, prefetches one byte per
//   plane every 8 pixels, serialises the bytes LSB-first and composes each
//   pixel from the plane masks and the border colour.
//
// Ports
//   clk, reset_n              system clock, asynchronous active-low reset
//   ce_pix                    pixel clock enable; nothing advances while 0
//   h, v                      beam counters (9 bit)
//   hb, vb                    horizontal / vertical blank
//   vdp_addr                  VRAM read address, common to all planes
//   fg1..fg3, bg1..bg3        plane bytes, valid one clk after vdp_addr
//   cmask                     [2:0] fg plane enables, [5:3] bg plane enables
//   bgc                       border / background colour, [2:0] = B,G,R
//   red, green, blue, de      composed pixel and display enable
//
// Fetch FSM
//   state   | meaning
//   S_IDLE  | no fetch in progress, waits for prefetch point of an active line
//   S_ADDR  | vdp_addr holds row_base+col, VRAM read in flight
//   S_LATCH | plane bytes captured into hold registers, col advanced
//   S_WAIT  | idle until the next group's prefetch point (6 ce)
module rx78_pixel_fetch #(
    parameter int H_START  = 28,
    parameter int V_START  = 20,
    parameter int H_ACTIVE = 192,
    parameter int V_ACTIVE = 184,
    parameter int LINE_B   = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce_pix,
    input  logic [8:0]  h,
    input  logic [8:0]  v,
    input  logic        hb,
    input  logic        vb,
    output logic [12:0] vdp_addr,
    input  logic [7:0]  fg1,
    input  logic [7:0]  fg2,
    input  logic [7:0]  fg3,
    input  logic [7:0]  bg1,
    input  logic [7:0]  bg2,
    input  logic [7:0]  bg3,
    input  logic [7:0]  cmask,
    input  logic [7:0]  bgc,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        de
);

    localparam logic [8:0]  H_LO     = 9'(H_START);
    localparam logic [8:0]  H_END    = 9'(H_START + H_ACTIVE);
    localparam logic [8:0]  H_FETCH  = 9'(H_START - 2);
    localparam logic [8:0]  V_LO     = 9'(V_START);
    localparam logic [8:0]  V_END    = 9'(V_START + V_ACTIVE);
    localparam logic [12:0] ROW_STEP = 13'(LINE_B);
    localparam logic [4:0]  COL_END  = 5'(LINE_B);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_LATCH = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       col_q, col_d;
    logic [12:0]      vdp_addr_q, vdp_addr_d;
    logic [12:0]      row_base_q, row_base_d;
    logic [5:0][7:0]  hold_q, hold_d;
    logic [5:0][7:0]  shift_q, shift_d;
    logic             line_act_q, line_act_d;
    logic [7:0]       red_q, red_d;
    logic [7:0]       green_q, green_d;
    logic [7:0]       blue_q, blue_d;
    logic             de_q, de_d;

    logic [5:0][7:0]  plane_in;
    logic             x_in, y_in, win_exit;
    logic [2:0]       x_phase;
    logic [2:0]       pix_f, pix_b;
    logic             unused_bits;

    assign plane_in    = {bg3, bg2, bg1, fg3, fg2, fg1};
    assign x_in        = (h >= H_LO) && (h < H_END);
    assign y_in        = (v >= V_LO) && (v < V_END);
    assign win_exit    = !y_in || (h >= H_END);
    // Position of h inside its 8-pixel group: 0 = load point, 6 = prefetch point.
    assign x_phase     = h[2:0] - H_LO[2:0];
    assign unused_bits = ^{cmask[7:6], bgc[7:3]};

    function automatic logic [23:0] rgb_of(input logic [2:0] c, input logic [7:0] lvl);
        return {c[0] ? lvl : 8'h00, c[1] ? lvl : 8'h00, c[2] ? lvl : 8'h00};
    endfunction

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        vdp_addr_d = vdp_addr_q;
        hold_d     = hold_q;
        line_act_d = line_act_q;

        case (state_q)
            S_IDLE: begin
                if (h == H_FETCH && y_in) begin
                    state_d    = S_ADDR;
                    col_d      = 5'd0;
                    vdp_addr_d = row_base_q;
                    line_act_d = 1'b1;
                end
            end
            S_ADDR: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                hold_d  = plane_in;
                col_d   = col_q + 5'd1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (x_phase == 3'd6) begin
                    if (col_q < COL_END) begin
                        state_d    = S_ADDR;
                        vdp_addr_d = row_base_q + 13'(col_q);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (win_exit) begin
            state_d    = S_IDLE;
            line_act_d = 1'b0;
        end
    end

    always_comb begin
        row_base_d = row_base_q;
        if (vb) begin
            row_base_d = 13'd0;
        end else if (h == H_END && y_in) begin
            row_base_d = row_base_q + ROW_STEP;
        end
    end

    // The load takes hold_d so a byte latched on the load ce is used at once.
    always_comb begin
        shift_d = shift_q;
        if (win_exit) begin
            shift_d = '0;
        end else if (x_in && x_phase == 3'd0) begin
            shift_d = hold_d;
        end else begin
            for (int p = 0; p < 6; p++) begin
                shift_d[p] = {1'b0, shift_q[p][7:1]};
            end
        end
    end

    // The pixel registered on this ce is bit 0 of the shifter's next value.
    always_comb begin
        pix_f = {shift_d[2][0], shift_d[1][0], shift_d[0][0]} & cmask[2:0];
        pix_b = {shift_d[5][0], shift_d[4][0], shift_d[3][0]} & cmask[5:3];
        {red_d, green_d, blue_d} = 24'h0;
        de_d = 1'b0;
        if (!(hb || vb)) begin
            if (x_in && y_in && line_act_q) begin
                de_d = 1'b1;
                if (pix_f != 3'b000) begin
                    {red_d, green_d, blue_d} = rgb_of(pix_f, 8'hFF);
                end else if (pix_b != 3'b000) begin
                    {red_d, green_d, blue_d} = rgb_of(pix_b, 8'h80);
                end else begin
                    {red_d, green_d, blue_d} = rgb_of(bgc[2:0], 8'h80);
                end
            end else begin
                {red_d, green_d, blue_d} = rgb_of(bgc[2:0], 8'h80);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            col_q      <= 5'd0;
            vdp_addr_q <= 13'd0;
            row_base_q <= 13'd0;
            hold_q     <= '0;
            shift_q    <= '0;
            line_act_q <= 1'b0;
            red_q      <= 8'h00;
            green_q    <= 8'h00;
            blue_q     <= 8'h00;
            de_q       <= 1'b0;
        end else if (ce_pix) begin
            state_q    <= state_d;
            col_q      <= col_d;
            vdp_addr_q <= vdp_addr_d;
            row_base_q <= row_base_d;
            hold_q     <= hold_d;
            shift_q    <= shift_d;
            line_act_q <= line_act_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
            de_q       <= de_d;
        end
    end

    assign vdp_addr = vdp_addr_q;
    assign red      = red_q;
    assign green    = green_q;
    assign blue     = blue_q;
    assign de       = de_q;

endmodule

// File: tb/tb_rx78_pixel_fetch.sv
module tb_rx78_pixel_fetch;

    localparam int H_START   = 28;
    localparam int V_START   = 20;
    localparam int H_ACTIVE  = 192;
    localparam int V_ACTIVE  = 184;
    localparam int LINE_B    = 24;
    localparam int H_TOTAL   = 248;
    localparam int VRAM_USED = 4416;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce_pix;
    logic [8:0]  h, v;
    logic        hb, vb;
    logic [12:0] vdp_addr;
    logic [7:0]  fg1, fg2, fg3, bg1, bg2, bg3;
    logic [7:0]  cmask, bgc;
    logic [7:0]  red, green, blue;
    logic        de;

    rx78_pixel_fetch dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ce_pix   (ce_pix),
        .h        (h),
        .v        (v),
        .hb       (hb),
        .vb       (vb),
        .vdp_addr (vdp_addr),
        .fg1      (fg1),
        .fg2      (fg2),
        .fg3      (fg3),
        .bg1      (bg1),
        .bg2      (bg2),
        .bg3      (bg3),
        .cmask    (cmask),
        .bgc      (bgc),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .de       (de)
    );

    always #5 clk = ~clk;

    // Plane memories: index 0..2 = fg1..fg3, 3..5 = bg1..bg3; synchronous read.
    logic [7:0] vram [6][VRAM_USED];

    always @(posedge clk) begin
        if (int'(vdp_addr) < VRAM_USED) begin
            fg1 <= vram[0][vdp_addr];
            fg2 <= vram[1][vdp_addr];
            fg3 <= vram[2][vdp_addr];
            bg1 <= vram[3][vdp_addr];
            bg2 <= vram[4][vdp_addr];
            bg3 <= vram[5][vdp_addr];
        end else begin
            {fg1, fg2, fg3, bg1, bg2, bg3} <= '0;
        end
    end

    int          total = 0;
    int          bad   = 0;
    bit          line_ok;
    logic [7:0]  er, eg, eb;
    logic        ede;
    logic [7:0]  cap_r [H_TOTAL];
    logic [7:0]  cap_g [H_TOTAL];
    logic [7:0]  cap_b [H_TOTAL];
    logic        cap_de [H_TOTAL];
    logic [12:0] cap_addr [H_TOTAL];
    logic [7:0]  cm_tab [H_TOTAL];
    logic [7:0]  bc_tab [H_TOTAL];
    bit          use_tab;
    int          rec_mode;
    logic [24:0] stream_q [$];

    // Reference picture: pixel (x,y) is bit x%8 of byte y*LINE_B + x/8.
    task automatic model_px(input int hh, input int vv, input bit hbb, input bit vbb);
        int x, y, a, n;
        logic [2:0] fb, bb, f, b, c;
        logic [7:0] lvl;
        x = hh - H_START;
        y = vv - V_START;
        if (hbb || vbb) begin
            er = 8'h00; eg = 8'h00; eb = 8'h00; ede = 1'b0;
        end else begin
            c   = bgc[2:0];
            lvl = 8'h80;
            ede = 1'b0;
            if (x >= 0 && x < H_ACTIVE && y >= 0 && y < V_ACTIVE && line_ok) begin
                ede = 1'b1;
                a = y * LINE_B + x / 8;
                n = x % 8;
                for (int i = 0; i < 3; i++) begin
                    fb[i] = vram[i][a][n];
                    bb[i] = vram[3 + i][a][n];
                end
                f = fb & cmask[2:0];
                b = bb & cmask[5:3];
                if (f != 3'b000) begin
                    c = f;
                    lvl = 8'hFF;
                end else if (b != 3'b000) begin
                    c = b;
                end
            end
            er = c[0] ? lvl : 8'h00;
            eg = c[1] ? lvl : 8'h00;
            eb = c[2] ? lvl : 8'h00;
        end
    endtask

    // One pixel: per-1 frozen clocks (ce=0) then one ce clock.
    task automatic step(input int hh, input int vv, input int per);
        logic [24:0] exp_s;
        h  = 9'(hh);
        v  = 9'(vv);
        hb = (hh < 16) || (hh >= 236);
        vb = (vv < 18) || (vv >= 206);
        if (use_tab) begin
            cmask = cm_tab[hh];
            bgc   = bc_tab[hh];
        end
        for (int i = 1; i < per; i++) begin
            ce_pix = 1'b0;
            @(posedge clk);
            #1;
            total++;
            if ({red, green, blue, de} !== {er, eg, eb, ede}) begin
                bad++;
                $display("FAIL freeze h=%0d v=%0d: got %h %h %h de=%b, want %h %h %h de=%b",
                         hh, vv, red, green, blue, de, er, eg, eb, ede);
            end
        end
        ce_pix = 1'b1;
        @(posedge clk);
        #1;
        ce_pix = 1'b0;
        if (hh == H_START - 2 && vv >= V_START && vv < V_START + V_ACTIVE) line_ok = 1'b1;
        model_px(hh, vv, hb, vb);
        total++;
        if ({red, green, blue, de} !== {er, eg, eb, ede}) begin
            bad++;
            $display("FAIL pixel h=%0d v=%0d: got %h %h %h de=%b, want %h %h %h de=%b",
                     hh, vv, red, green, blue, de, er, eg, eb, ede);
        end
        if (hh < H_TOTAL) begin
            cap_r[hh] = red; cap_g[hh] = green; cap_b[hh] = blue;
            cap_de[hh] = de; cap_addr[hh] = vdp_addr;
        end
        if (rec_mode == 1) begin
            stream_q.push_back({red, green, blue, de});
        end else if (rec_mode == 2) begin
            total++;
            if (stream_q.size() == 0) begin
                bad++;
                $display("FAIL stretch h=%0d v=%0d: extra pixel %h %h %h de=%b", hh, vv, red, green, blue, de);
            end else begin
                exp_s = stream_q.pop_front();
                if ({red, green, blue, de} !== exp_s) begin
                    bad++;
                    $display("FAIL stretch h=%0d v=%0d: got %h, want %h", hh, vv, {red, green, blue, de}, exp_s);
                end
            end
        end
    endtask

    task automatic run_line(input int vv, input int per);
        for (int hh = 0; hh < H_TOTAL; hh++) step(hh, vv, per);
    endtask

    task automatic vblank();
        step(0, 0, 1);
    endtask

    task automatic test_reset();
        int n_de;
        reset_n = 1'b0;
        ce_pix = 1'b1;
        h = 9'd100; v = 9'd30; hb = 1'b0; vb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({red, green, blue, de} !== 25'h0) begin
            bad++;
            $display("FAIL reset_out: got %h %h %h de=%b, want 0", red, green, blue, de);
        end
        total++;
        if (vdp_addr !== 13'd0) begin
            bad++;
            $display("FAIL reset_addr: got %0d, want 0", vdp_addr);
        end
        ce_pix = 1'b0;
        #2 reset_n = 1'b1;
        line_ok = 1'b0; er = 8'h00; eg = 8'h00; eb = 8'h00; ede = 1'b0;
        vblank();
        for (int hh = 0; hh < 100; hh++) step(hh, V_START, 1);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({red, green, blue, de, vdp_addr} !== 38'h0) begin
            bad++;
            $display("FAIL midline_reset: got %h %h %h de=%b addr=%0d, want 0", red, green, blue, de, vdp_addr);
        end
        @(posedge clk);
        #2 reset_n = 1'b1;
        line_ok = 1'b0; er = 8'h00; eg = 8'h00; eb = 8'h00; ede = 1'b0;
        for (int hh = 100; hh < H_TOTAL; hh++) step(hh, V_START, 1);
        n_de = 0;
        for (int hh = 100; hh < H_TOTAL; hh++) if (cap_de[hh] === 1'b1) n_de++;
        total++;
        if (n_de !== 0) begin
            bad++;
            $display("FAIL de_after_release: got %0d de pixels, want 0", n_de);
        end
        run_line(V_START + 1, 1);
        total++;
        if (cap_de[H_START] !== 1'b1) begin
            bad++;
            $display("FAIL de_next_line: got %b, want 1", cap_de[H_START]);
        end
    endtask

    task automatic test_fg_pixel();
        for (int p = 0; p < 6; p++) vram[p][0] = 8'h00;
        vram[0][0] = 8'h01;
        cmask = 8'h07;
        bgc = 8'h05;
        vblank();
        run_line(V_START, 1);
        total++;
        if ({cap_r[H_START], cap_g[H_START], cap_b[H_START], cap_de[H_START]} !== {8'hFF, 8'h00, 8'h00, 1'b1}) begin
            bad++;
            $display("FAIL fg_x0: got %h %h %h de=%b, want ff 00 00 de=1",
                     cap_r[H_START], cap_g[H_START], cap_b[H_START], cap_de[H_START]);
        end
        for (int x = 1; x < 8; x++) begin
            total++;
            if ({cap_r[H_START + x], cap_g[H_START + x], cap_b[H_START + x], cap_de[H_START + x]} !== {8'h80, 8'h00, 8'h80, 1'b1}) begin
                bad++;
                $display("FAIL fg_border x=%0d: got %h %h %h de=%b, want 80 00 80 de=1", x,
                         cap_r[H_START + x], cap_g[H_START + x], cap_b[H_START + x], cap_de[H_START + x]);
            end
        end
    endtask

    task automatic test_bg_addr();
        for (int p = 0; p < 6; p++) vram[p][24] = 8'h00;
        vram[4][24] = 8'hFF;
        cmask = 8'h38;
        bgc = 8'h07;
        vblank();
        run_line(V_START, 1);
        run_line(V_START + 1, 1);
        total++;
        if (cap_addr[H_START - 2] !== 13'd24) begin
            bad++;
            $display("FAIL addr_line1: got %0d, want 24", cap_addr[H_START - 2]);
        end
        for (int x = 0; x < 8; x++) begin
            total++;
            if ({cap_r[H_START + x], cap_g[H_START + x], cap_b[H_START + x], cap_de[H_START + x]} !== {8'h00, 8'h80, 8'h00, 1'b1}) begin
                bad++;
                $display("FAIL bg_green x=%0d: got %h %h %h de=%b, want 00 80 00 de=1", x,
                         cap_r[H_START + x], cap_g[H_START + x], cap_b[H_START + x], cap_de[H_START + x]);
            end
        end
    endtask

    task automatic test_priority();
        for (int p = 0; p < 6; p++) vram[p][0] = 8'h00;
        vram[0][0] = 8'hFF;
        vram[5][0] = 8'hFF;
        bgc = 8'h02;
        cmask = 8'h38;
        vblank();
        run_line(V_START, 1);
        for (int x = 0; x < 8; x += 7) begin
            total++;
            if ({cap_r[H_START + x], cap_g[H_START + x], cap_b[H_START + x]} !== {8'h00, 8'h00, 8'h80}) begin
                bad++;
                $display("FAIL fg_masked x=%0d: got %h %h %h, want 00 00 80", x,
                         cap_r[H_START + x], cap_g[H_START + x], cap_b[H_START + x]);
            end
        end
        cmask = 8'h3F;
        vblank();
        run_line(V_START, 1);
        for (int x = 0; x < 8; x += 7) begin
            total++;
            if ({cap_r[H_START + x], cap_g[H_START + x], cap_b[H_START + x]} !== {8'hFF, 8'h00, 8'h00}) begin
                bad++;
                $display("FAIL fg_wins x=%0d: got %h %h %h, want ff 00 00", x,
                         cap_r[H_START + x], cap_g[H_START + x], cap_b[H_START + x]);
            end
        end
    endtask

    task automatic test_last_line();
        cmask = 8'h3F;
        bgc = 8'h04;
        vblank();
        for (int y = 0; y < V_ACTIVE - 1; y++) step(H_START + H_ACTIVE, V_START + y, 1);
        run_line(V_START + V_ACTIVE - 1, 1);
        total++;
        if (cap_addr[202] !== 13'd4414) begin
            bad++;
            $display("FAIL addr_col22: got %0d, want 4414", cap_addr[202]);
        end
        total++;
        if (cap_addr[210] !== 13'd4415) begin
            bad++;
            $display("FAIL addr_col23: got %0d, want 4415", cap_addr[210]);
        end
        total++;
        if (cap_addr[H_TOTAL - 1] !== 13'd4415) begin
            bad++;
            $display("FAIL addr_after_line: got %0d, want 4415", cap_addr[H_TOTAL - 1]);
        end
        total++;
        if ({cap_de[219], cap_de[220]} !== 2'b10) begin
            bad++;
            $display("FAIL de_edge: got %b%b, want 10", cap_de[219], cap_de[220]);
        end
    endtask

    task automatic test_random_lines();
        vblank();
        for (int y = 0; y < 6; y++) begin
            cmask = 8'($urandom);
            bgc = 8'($urandom);
            run_line(V_START + y, 1);
        end
    endtask

    task automatic test_ce_stretch();
        logic [7:0] cm, bc;
        cm = 8'($urandom);
        bc = 8'($urandom);
        for (int hh = 0; hh < H_TOTAL; hh++) begin
            if ($urandom_range(0, 7) == 0) cm = 8'($urandom);
            if ($urandom_range(0, 7) == 0) bc = 8'($urandom);
            cm_tab[hh] = cm;
            bc_tab[hh] = bc;
        end
        use_tab = 1'b1;
        stream_q.delete();
        vblank();
        rec_mode = 1;
        for (int y = 0; y < 3; y++) run_line(V_START + y, 1);
        rec_mode = 0;
        vblank();
        rec_mode = 2;
        for (int y = 0; y < 3; y++) run_line(V_START + y, 4);
        rec_mode = 0;
        use_tab = 1'b0;
        total++;
        if (stream_q.size() != 0) begin
            bad++;
            $display("FAIL stretch_count: %0d pixels missing", stream_q.size());
        end
    endtask

    initial begin
        reset_n = 1'b0;
        ce_pix = 1'b0;
        h = 9'd0; v = 9'd0; hb = 1'b1; vb = 1'b1;
        cmask = 8'h3F;
        bgc = 8'h03;
        use_tab = 1'b0;
        rec_mode = 0;
        line_ok = 1'b0;
        er = 8'h00; eg = 8'h00; eb = 8'h00; ede = 1'b0;
        for (int p = 0; p < 6; p++)
            for (int a = 0; a < VRAM_USED; a++) vram[p][a] = 8'($urandom);

        test_reset();
        test_fg_pixel();
        test_bg_addr();
        test_priority();
        test_last_line();
        test_random_lines();
        test_ce_stretch();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
